// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the pwm_fader block.
package pwm_pkg;

  localparam int unsigned DEFAULT_MAX_VALUE = 32'd1000;
  localparam int unsigned DEFAULT_PRESCALE  = 32'd250;

  // LSB position of channel ch inside a packed per-channel bus.
  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned bits);
    return ch * bits;
  endfunction

  function automatic int unsigned clamp_max(input int unsigned v, input int unsigned max_v);
    if (v > max_v) begin
      return max_v;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/pwm_slew.sv
// Per-channel fade engine: captured target, active duty and settled flag.
module pwm_slew
  import pwm_pkg::*;
#(
  parameter int unsigned BITS      = 32'd10,
  parameter int unsigned MAX_VALUE = DEFAULT_MAX_VALUE
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wrap,
  input  logic            load,
  input  logic [BITS-1:0] load_value,
  input  logic [BITS-1:0] fade_step,
  output logic [BITS-1:0] duty,
  output logic            settled
);

  localparam int unsigned W1 = BITS + 32'd1;

  logic [BITS-1:0] target_r;
  logic [BITS-1:0] target_next_s;
  logic [BITS-1:0] duty_next_s;
  logic [BITS:0]   diff_s;

  // Next target from a load strobe, next duty from one fade step at the wrap.
  always_comb begin
    target_next_s = target_r;
    duty_next_s   = duty;
    diff_s        = {W1{1'b0}};
    if (load) begin
      target_next_s = BITS'(clamp_max(32'(load_value), MAX_VALUE));
    end else begin
      target_next_s = target_r;
    end
    if (wrap) begin
      if (target_r >= duty) begin
        diff_s = {1'b0, target_r} - {1'b0, duty};
      end else begin
        diff_s = {1'b0, duty} - {1'b0, target_r};
      end
      if ((fade_step == {BITS{1'b0}}) || (diff_s <= {1'b0, fade_step})) begin
        duty_next_s = target_r;
      end else if (target_r > duty) begin
        duty_next_s = BITS'({1'b0, duty} + {1'b0, fade_step});
      end else begin
        duty_next_s = BITS'({1'b0, duty} - {1'b0, fade_step});
      end
    end else begin
      duty_next_s = duty;
    end
  end

  // Channel state registers; settled is taken from the post-update values.
  always_ff @(posedge clock) begin
    if (reset) begin
      target_r <= {BITS{1'b0}};
      duty     <= {BITS{1'b0}};
      settled  <= 1'b1;
    end else begin
      target_r <= target_next_s;
      duty     <= duty_next_s;
      settled  <= (duty_next_s == target_next_s);
    end
  end

endmodule

// File: rtl/pwm_fader.sv
// Multi-channel PWM with per-channel fade engines.
// Optional macro PWM_PHASE_STAGGER_EN offsets each channel's compare phase.
module pwm_fader
  import pwm_pkg::*;
#(
  parameter int unsigned CHANNELS      = 32'd2,
  parameter int unsigned BITS          = 32'd10,
  parameter int unsigned MAX_VALUE     = DEFAULT_MAX_VALUE,
  parameter int unsigned PRESCALE      = DEFAULT_PRESCALE,
  parameter int unsigned PRESCALE_BITS = 32'd8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CHANNELS*BITS-1:0] target,
  input  logic [CHANNELS-1:0]      target_load,
  input  logic [BITS-1:0]          fade_step,
  output logic [CHANNELS-1:0]      signal,
  output logic [CHANNELS*BITS-1:0] duty,
  output logic [CHANNELS-1:0]      settled,
  output logic                     period_start
);

  localparam logic [PRESCALE_BITS-1:0] PRESC_LAST = PRESCALE_BITS'(PRESCALE - 32'd1);
  localparam logic [BITS-1:0]          COUNT_LAST = BITS'(MAX_VALUE - 32'd1);

  if ((MAX_VALUE >> BITS) != 32'd0) begin : g_bad_max
    $error("pwm_fader: MAX_VALUE does not fit in BITS");
  end
  if ((PRESCALE == 32'd0) || (((PRESCALE - 32'd1) >> PRESCALE_BITS) != 32'd0)) begin : g_bad_presc
    $error("pwm_fader: PRESCALE-1 does not fit in PRESCALE_BITS");
  end

  logic [PRESCALE_BITS-1:0] presc_r;
  logic [BITS-1:0]          count_r;
  logic                     tick_s;
  logic                     wrap_s;
  logic [CHANNELS-1:0]      cmp_s;

  assign tick_s = (presc_r == PRESC_LAST);
  assign wrap_s = tick_s && (count_r == COUNT_LAST);

  // Shared prescaler, period counter and period-start pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_r      <= {PRESCALE_BITS{1'b0}};
      count_r      <= {BITS{1'b0}};
      period_start <= 1'b0;
    end else begin
      if (tick_s) begin
        presc_r <= {PRESCALE_BITS{1'b0}};
      end else begin
        presc_r <= presc_r + {{(PRESCALE_BITS-1){1'b0}}, 1'b1};
      end
      if (wrap_s) begin
        count_r <= {BITS{1'b0}};
      end else if (tick_s) begin
        count_r <= count_r + {{(BITS-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end
      period_start <= wrap_s;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [BITS-1:0] phase_s;

`ifdef PWM_PHASE_STAGGER_EN
    localparam int unsigned W1     = BITS + 32'd1;
    localparam int unsigned OFFSET = i * (MAX_VALUE / CHANNELS);
    logic [BITS:0] sum_s;
    // Sum stays below 2*MAX_VALUE, so a single conditional subtract is a full modulo.
    assign sum_s   = {1'b0, count_r} + W1'(OFFSET);
    assign phase_s = (sum_s >= W1'(MAX_VALUE)) ? BITS'(sum_s - W1'(MAX_VALUE)) : BITS'(sum_s);
`else
    assign phase_s = count_r;
`endif

    assign cmp_s[i] = (phase_s < duty[ch_lsb(i, BITS) +: BITS]);

    pwm_slew #(
      .BITS      (BITS),
      .MAX_VALUE (MAX_VALUE)
    ) u_slew (
      .clock      (clock),
      .reset      (reset),
      .wrap       (wrap_s),
      .load       (target_load[i]),
      .load_value (target[ch_lsb(i, BITS) +: BITS]),
      .fade_step  (fade_step),
      .duty       (duty[ch_lsb(i, BITS) +: BITS]),
      .settled    (settled[i])
    );
  end

  // Registered compare outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      signal <= {CHANNELS{1'b0}};
    end else begin
      signal <= cmp_s;
    end
  end

endmodule
